// File: rtl/rom_dl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : rom_dl_pkg
//  Description : Shared types and constants for the ROM-download sequencer:
//                region encoding, address map and FSM state codes.
//  Revision    : 1.0 - initial release
// ============================================================================
package rom_dl_pkg;

  // Destination region of a download byte
  typedef enum logic [2:0] {
    REG_PROG = 3'd0,
    REG_CHAR = 3'd1,
    REG_CAR  = 3'd2,
    REG_PROM = 3'd3,
    REG_NONE = 3'd4
  } region_t;

  // Download address map (byte addresses within the ROM image)
  localparam logic [24:0] PROG_BASE = 25'h000_0000;
  localparam logic [24:0] PROG_SIZE = 25'h000_2000;
  localparam logic [24:0] CHAR_BASE = 25'h000_2000;
  localparam logic [24:0] CHAR_SIZE = 25'h000_0800;
  localparam logic [24:0] CAR_BASE  = 25'h000_2800;
  localparam logic [24:0] CAR_SIZE  = 25'h000_0800;
  localparam logic [24:0] PROM_BASE = 25'h000_3000;
  localparam logic [24:0] PROM_SIZE = 25'h000_0100;
  localparam logic [24:0] MAP_END   = PROM_BASE + PROM_SIZE;

  localparam int unsigned LADDR_W = 13;

  // Sequencer states
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_LOAD  = 2'd1;
  localparam logic [1:0] ST_WRITE = 2'd2;
  localparam logic [1:0] ST_HOLD  = 2'd3;

  // One-hot ROM select for a region; REG_NONE selects nothing
  function automatic logic [3:0] region_sel(input region_t r);
    logic [3:0] sel;
    case (r)
      REG_PROG: sel = 4'b0001;
      REG_CHAR: sel = 4'b0010;
      REG_CAR:  sel = 4'b0100;
      REG_PROM: sel = 4'b1000;
      default:  sel = 4'b0000;
    endcase
    return sel;
  endfunction

endpackage
`default_nettype wire

// File: rtl/rom_dl_decode.sv
`default_nettype none
// ============================================================================
//  Module      : rom_dl_decode
//  Description : Combinational decode of an ioctl byte address into a ROM
//                region, a 13-bit region-local address and an in-map flag.
//  Revision    : 1.0 - initial release
// ============================================================================
module rom_dl_decode
  import rom_dl_pkg::*;
(
  input  logic [24:0]        addr,
  output region_t            region,
  output logic [LADDR_W-1:0] local_addr,
  output logic               in_map
);

  logic [LADDR_W-1:0] base;

  // Pick the region by range and subtract its base; the subtraction only
  // needs the low 13 bits because the local address is truncated anyway.
  always_comb begin
    region = REG_NONE;
    base   = '0;
    if (addr < CHAR_BASE) begin
      region = REG_PROG;
      base   = PROG_BASE[LADDR_W-1:0];
    end else if (addr < CAR_BASE) begin
      region = REG_CHAR;
      base   = CHAR_BASE[LADDR_W-1:0];
    end else if (addr < PROM_BASE) begin
      region = REG_CAR;
      base   = CAR_BASE[LADDR_W-1:0];
    end else if (addr < MAP_END) begin
      region = REG_PROM;
      base   = PROM_BASE[LADDR_W-1:0];
    end
    in_map     = (region != REG_NONE);
    local_addr = addr[LADDR_W-1:0] - base;
  end

endmodule
`default_nettype wire

// File: rtl/rom_dl_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : rom_dl_sequencer
//  Description : Paces HPS ioctl ROM-download bytes into the core's ROM
//                regions, applies ioctl_wait backpressure for each write and
//                holds the game core in reset across the download.
//                Optional build macro DL_CHECKSUM_EN adds a running byte
//                checksum (dl_sum) and a mismatch flag (dl_bad).
//  Revision    : 1.0 - initial release
// ============================================================================
module rom_dl_sequencer
  import rom_dl_pkg::*;
#(
  parameter int unsigned WE_CYCLES   = 2,
  parameter int unsigned HOLD_CYCLES = 16,
  parameter int unsigned ROM_INDEX   = 0
`ifdef DL_CHECKSUM_EN
  ,
  parameter logic [15:0] EXP_SUM     = 16'h0000
`endif
) (
  input  logic         clk_sys,
  input  logic         reset,
  input  logic         ioctl_download,
  input  logic [7:0]   ioctl_index,
  input  logic         ioctl_wr,
  input  logic [24:0]  ioctl_addr,
  input  logic [7:0]   ioctl_data,
  output logic         ioctl_wait,
  output logic [3:0]   rom_sel,
  output logic [12:0]  rom_addr,
  output logic [7:0]   rom_data,
  output logic         rom_we,
  output logic         core_reset,
  output logic         dl_done,
  output logic         dl_err
`ifdef DL_CHECKSUM_EN
  ,
  output logic [15:0]  dl_sum,
  output logic         dl_bad
`endif
);

  localparam logic [3:0] WCNT_INIT = 4'(WE_CYCLES - 1);
  localparam logic [7:0] HCNT_INIT = 8'(HOLD_CYCLES - 1);
  localparam logic [7:0] ROM_IDX   = 8'(ROM_INDEX);

  region_t            dec_region;
  logic [LADDR_W-1:0] dec_local;
  logic               dec_in_map;

  logic [1:0]  state_q,      state_d;
  logic [3:0]  wcnt_q,       wcnt_d;
  logic [7:0]  hcnt_q,       hcnt_d;
  logic        pend_q,       pend_d;
  logic [3:0]  cap_sel_q,    cap_sel_d;
  logic [3:0]  rom_sel_q,    rom_sel_d;
  logic [12:0] rom_addr_q,   rom_addr_d;
  logic [7:0]  rom_data_q,   rom_data_d;
  logic        rom_we_q,     rom_we_d;
  logic        ioctl_wait_q, ioctl_wait_d;
  logic        core_reset_q, core_reset_d;
  logic        dl_done_q,    dl_done_d;
  logic        dl_err_q,     dl_err_d;

  logic        w_start;

  rom_dl_decode u_decode (
    .addr       (ioctl_addr),
    .region     (dec_region),
    .local_addr (dec_local),
    .in_map     (dec_in_map)
  );

  assign w_start = ioctl_download && (ioctl_index == ROM_IDX);

  // Next-state logic: capture a byte, then hold rom_we/ioctl_wait for
  // WE_CYCLES clocks; keep the core in reset until HOLD expires.
  always_comb begin
    state_d      = state_q;
    wcnt_d       = wcnt_q;
    hcnt_d       = hcnt_q;
    pend_d       = pend_q;
    cap_sel_d    = cap_sel_q;
    rom_sel_d    = rom_sel_q;
    rom_addr_d   = rom_addr_q;
    rom_data_d   = rom_data_q;
    rom_we_d     = rom_we_q;
    ioctl_wait_d = ioctl_wait_q;
    core_reset_d = core_reset_q;
    dl_done_d    = dl_done_q;
    dl_err_d     = dl_err_q;

    case (state_q)
      ST_IDLE: begin
        if (w_start) begin
          state_d      = ST_LOAD;
          pend_d       = 1'b0;
          core_reset_d = 1'b1;
          dl_done_d    = 1'b0;
          dl_err_d     = 1'b0;
        end
      end

      ST_LOAD: begin
        if (pend_q) begin
          // Captured byte goes out now; a strobe here is an overrun and is
          // dropped because nothing can hold a second byte.
          if (ioctl_wr) dl_err_d = 1'b1;
          pend_d       = 1'b0;
          rom_sel_d    = cap_sel_q;
          rom_we_d     = 1'b1;
          ioctl_wait_d = 1'b1;
          wcnt_d       = WCNT_INIT;
          state_d      = ST_WRITE;
        end else if (ioctl_wr) begin
          if (dec_in_map) begin
            // A falling download in the same cycle is handled after the
            // write completes, so the byte is not lost.
            pend_d     = 1'b1;
            cap_sel_d  = region_sel(dec_region);
            rom_addr_d = dec_local;
            rom_data_d = ioctl_data;
          end else begin
            dl_err_d = 1'b1;
            if (!ioctl_download) begin
              state_d = ST_HOLD;
              hcnt_d  = HCNT_INIT;
            end
          end
        end else if (!ioctl_download) begin
          state_d = ST_HOLD;
          hcnt_d  = HCNT_INIT;
        end
      end

      ST_WRITE: begin
        if (ioctl_wr) dl_err_d = 1'b1;
        if (wcnt_q == 4'd0) begin
          rom_we_d     = 1'b0;
          ioctl_wait_d = 1'b0;
          rom_sel_d    = 4'b0000;
          if (ioctl_download) begin
            state_d = ST_LOAD;
          end else begin
            state_d = ST_HOLD;
            hcnt_d  = HCNT_INIT;
          end
        end else begin
          wcnt_d = wcnt_q - 4'd1;
        end
      end

      default: begin // ST_HOLD
        core_reset_d = 1'b1;
        if (w_start) begin
          state_d   = ST_LOAD;
          pend_d    = 1'b0;
          dl_done_d = 1'b0;
          dl_err_d  = 1'b0;
        end else if (hcnt_q == 8'd0) begin
          core_reset_d = 1'b0;
          dl_done_d    = 1'b1;
          state_d      = ST_IDLE;
        end else begin
          hcnt_d = hcnt_q - 8'd1;
        end
      end
    endcase
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      wcnt_q       <= '0;
      hcnt_q       <= '0;
      pend_q       <= 1'b0;
      cap_sel_q    <= '0;
      rom_sel_q    <= '0;
      rom_addr_q   <= '0;
      rom_data_q   <= '0;
      rom_we_q     <= 1'b0;
      ioctl_wait_q <= 1'b0;
      core_reset_q <= 1'b1;
      dl_done_q    <= 1'b0;
      dl_err_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      wcnt_q       <= wcnt_d;
      hcnt_q       <= hcnt_d;
      pend_q       <= pend_d;
      cap_sel_q    <= cap_sel_d;
      rom_sel_q    <= rom_sel_d;
      rom_addr_q   <= rom_addr_d;
      rom_data_q   <= rom_data_d;
      rom_we_q     <= rom_we_d;
      ioctl_wait_q <= ioctl_wait_d;
      core_reset_q <= core_reset_d;
      dl_done_q    <= dl_done_d;
      dl_err_q     <= dl_err_d;
    end
  end

  assign ioctl_wait = ioctl_wait_q;
  assign rom_sel    = rom_sel_q;
  assign rom_addr   = rom_addr_q;
  assign rom_data   = rom_data_q;
  assign rom_we     = rom_we_q;
  assign core_reset = core_reset_q;
  assign dl_done    = dl_done_q;
  assign dl_err     = dl_err_q;

`ifdef DL_CHECKSUM_EN
  logic [15:0] sum_q, sum_d;
  logic        w_load_entry;
  logic        w_accept;

  assign w_load_entry = w_start && ((state_q == ST_IDLE) || (state_q == ST_HOLD));
  assign w_accept     = (state_q == ST_LOAD) && !pend_q && ioctl_wr && dec_in_map;

  // Running sum of accepted in-map bytes, restarted with each download
  always_comb begin
    sum_d = sum_q;
    if (w_load_entry) begin
      sum_d = '0;
    end else if (w_accept) begin
      sum_d = sum_q + {8'h00, ioctl_data};
    end
  end

  // Checksum register
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      sum_q <= '0;
    end else begin
      sum_q <= sum_d;
    end
  end

  assign dl_sum = sum_q;
  assign dl_bad = dl_done_q && (sum_q != EXP_SUM);
`endif

endmodule
`default_nettype wire

// File: tb/tb_rom_dl_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_rom_dl_sequencer
//  Description : Directed self-checking bench for rom_dl_sequencer
//                (WE_CYCLES=2, HOLD_CYCLES=16, ROM_INDEX=0).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_rom_dl_sequencer;

  logic        clk_sys = 1'b0;
  logic        reset;
  logic        ioctl_download;
  logic [7:0]  ioctl_index;
  logic        ioctl_wr;
  logic [24:0] ioctl_addr;
  logic [7:0]  ioctl_data;
  logic        ioctl_wait;
  logic [3:0]  rom_sel;
  logic [12:0] rom_addr;
  logic [7:0]  rom_data;
  logic        rom_we;
  logic        core_reset;
  logic        dl_done;
  logic        dl_err;
`ifdef DL_CHECKSUM_EN
  logic [15:0] dl_sum;
  logic        dl_bad;
`endif

  int checks   = 0;
  int failures = 0;

  rom_dl_sequencer #(
    .WE_CYCLES   (2),
    .HOLD_CYCLES (16),
    .ROM_INDEX   (0)
  ) dut (
    .clk_sys        (clk_sys),
    .reset          (reset),
    .ioctl_download (ioctl_download),
    .ioctl_index    (ioctl_index),
    .ioctl_wr       (ioctl_wr),
    .ioctl_addr     (ioctl_addr),
    .ioctl_data     (ioctl_data),
    .ioctl_wait     (ioctl_wait),
    .rom_sel        (rom_sel),
    .rom_addr       (rom_addr),
    .rom_data       (rom_data),
    .rom_we         (rom_we),
    .core_reset     (core_reset),
    .dl_done        (dl_done),
    .dl_err         (dl_err)
`ifdef DL_CHECKSUM_EN
    ,
    .dl_sum         (dl_sum),
    .dl_bad         (dl_bad)
`endif
  );

  always #5 clk_sys = ~clk_sys;

  // Advance one clock; sample and drive 1 ns after the rising edge
  task automatic step();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One in-map byte with full timing check: capture clock, then WE for 2 clocks
  task automatic send_byte(input string tag, input logic [24:0] a, input logic [7:0] d,
                           input logic [3:0] esel, input logic [12:0] eaddr);
    ioctl_wr   = 1'b1;
    ioctl_addr = a;
    ioctl_data = d;
    step();
    ioctl_wr = 1'b0;
    chk({tag, ".we_capture"}, rom_we, 1'b0);
    step();
    chk({tag, ".we1"},   rom_we, 1'b1);
    chk({tag, ".wait1"}, ioctl_wait, 1'b1);
    chk({tag, ".sel"},   rom_sel, esel);
    chk({tag, ".addr"},  rom_addr, eaddr);
    chk({tag, ".data"},  rom_data, d);
    step();
    chk({tag, ".we2"},   rom_we, 1'b1);
    chk({tag, ".wait2"}, ioctl_wait, 1'b1);
    step();
    chk({tag, ".we_off"},   rom_we, 1'b0);
    chk({tag, ".wait_off"}, ioctl_wait, 1'b0);
    chk({tag, ".sel_off"},  rom_sel, 4'b0000);
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  initial begin
    reset          = 1'b1;
    ioctl_download = 1'b0;
    ioctl_index    = 8'd0;
    ioctl_wr       = 1'b0;
    ioctl_addr     = '0;
    ioctl_data     = '0;
    repeat (3) step();

    // Reset values
    chk("rst.wait",  ioctl_wait, 1'b0);
    chk("rst.sel",   rom_sel, 4'b0000);
    chk("rst.addr",  rom_addr, 13'h0000);
    chk("rst.data",  rom_data, 8'h00);
    chk("rst.we",    rom_we, 1'b0);
    chk("rst.creset", core_reset, 1'b1);
    chk("rst.done",  dl_done, 1'b0);
    chk("rst.err",   dl_err, 1'b0);
    reset = 1'b0;
    step();

    // Download 1: three bytes into PROG, CHAR, PROM
    ioctl_download = 1'b1;
    step();
    chk("dl1.creset", core_reset, 1'b1);
    send_byte("b0", 25'h0000, 8'hA5, 4'b0001, 13'h000);
    send_byte("b1", 25'h2001, 8'h5A, 4'b0010, 13'h001);
    send_byte("b2", 25'h3005, 8'h3C, 4'b1000, 13'h005);

    // End of download: core_reset falls 16 clocks after the fall is sampled
    ioctl_download = 1'b0;
    step();
    chk("hold.start_creset", core_reset, 1'b1);
    repeat (14) step();
    step();
    chk("hold.15_creset", core_reset, 1'b1);
    chk("hold.15_done",   dl_done, 1'b0);
    step();
    chk("hold.16_creset", core_reset, 1'b0);
    chk("hold.16_done",   dl_done, 1'b1);

    // Non-matching index: nothing happens, core stays out of reset
    ioctl_download = 1'b1;
    ioctl_index    = 8'd3;
    step();
    ioctl_wr   = 1'b1;
    ioctl_addr = 25'h0010;
    ioctl_data = 8'h77;
    step();
    ioctl_wr = 1'b0;
    step();
    chk("idx3.wait",   ioctl_wait, 1'b0);
    chk("idx3.we",     rom_we, 1'b0);
    chk("idx3.creset", core_reset, 1'b0);
    step();
    chk("idx3.we_late", rom_we, 1'b0);
    ioctl_download = 1'b0;
    ioctl_index    = 8'd0;
    step();

    // Download 2: out-of-map byte sets sticky error
    ioctl_download = 1'b1;
    step();
    chk("dl2.creset", core_reset, 1'b1);
    chk("dl2.done_clr", dl_done, 1'b0);
    ioctl_wr   = 1'b1;
    ioctl_addr = 25'h3100;
    ioctl_data = 8'hEE;
    step();
    ioctl_wr = 1'b0;
    chk("oom.err", dl_err, 1'b1);
    chk("oom.we0", rom_we, 1'b0);
    step();
    chk("oom.we1",   rom_we, 1'b0);
    chk("oom.wait1", ioctl_wait, 1'b0);
    ioctl_download = 1'b0;
    repeat (17) step();
    chk("dl2.done", dl_done, 1'b1);
    chk("dl2.err_sticky", dl_err, 1'b1);

    // Download 3: error cleared at start, then overrun
    ioctl_download = 1'b1;
    step();
    chk("dl3.err_clr", dl_err, 1'b0);
    ioctl_wr   = 1'b1;
    ioctl_addr = 25'h0010;
    ioctl_data = 8'h11;
    step();
    ioctl_addr = 25'h0020;
    ioctl_data = 8'h22;
    step();
    ioctl_wr = 1'b0;
    chk("ovr.we",   rom_we, 1'b1);
    chk("ovr.addr", rom_addr, 13'h010);
    chk("ovr.data", rom_data, 8'h11);
    chk("ovr.err",  dl_err, 1'b1);
    repeat (2) step();
    chk("ovr.we_off", rom_we, 1'b0);
    step();
    chk("ovr.no_second_we",   rom_we, 1'b0);
    chk("ovr.no_second_addr", rom_addr, 13'h010);

    // Write strobe and download fall in the same cycle: byte written, then HOLD
    ioctl_wr       = 1'b1;
    ioctl_addr     = 25'h2800;
    ioctl_data     = 8'h77;
    ioctl_download = 1'b0;
    step();
    ioctl_wr = 1'b0;
    step();
    chk("wrfall.we",   rom_we, 1'b1);
    chk("wrfall.sel",  rom_sel, 4'b0100);
    chk("wrfall.addr", rom_addr, 13'h000);
    repeat (2) step();
    chk("wrfall.we_off", rom_we, 1'b0);
    chk("wrfall.creset", core_reset, 1'b1);
    repeat (3) step();

    // Re-start during HOLD: back to LOAD, core stays in reset, error cleared
    ioctl_download = 1'b1;
    step();
    chk("abort.creset", core_reset, 1'b1);
    chk("abort.err_clr", dl_err, 1'b0);
    send_byte("b3", 25'h3001, 8'h99, 4'b1000, 13'h001);

    // Download falls during WRITE: straight to HOLD after the write
    ioctl_wr   = 1'b1;
    ioctl_addr = 25'h0100;
    ioctl_data = 8'h42;
    step();
    ioctl_wr = 1'b0;
    step();
    chk("wfall.we", rom_we, 1'b1);
    ioctl_download = 1'b0;
    repeat (2) step();
    chk("wfall.we_off", rom_we, 1'b0);
    repeat (15) step();
    chk("wfall.15_creset", core_reset, 1'b1);
    step();
    chk("wfall.16_creset", core_reset, 1'b0);
    chk("wfall.16_done",   dl_done, 1'b1);

    // Reset in the middle of a write
    ioctl_download = 1'b1;
    step();
    ioctl_wr   = 1'b1;
    ioctl_addr = 25'h0005;
    ioctl_data = 8'h5A;
    step();
    ioctl_wr = 1'b0;
    step();
    chk("rmid.we_before", rom_we, 1'b1);
    reset = 1'b1;
    step();
    chk("rmid.we",     rom_we, 1'b0);
    chk("rmid.wait",   ioctl_wait, 1'b0);
    chk("rmid.sel",    rom_sel, 4'b0000);
    chk("rmid.addr",   rom_addr, 13'h000);
    chk("rmid.creset", core_reset, 1'b1);
    chk("rmid.done",   dl_done, 1'b0);
    reset          = 1'b0;
    ioctl_download = 1'b0;
    step();

`ifdef DL_CHECKSUM_EN
    // Checksum: 0xFF + 0xFF + 0x02 = 0x0200, EXP_SUM left at 0
    ioctl_download = 1'b1;
    step();
    send_byte("s0", 25'h0000, 8'hFF, 4'b0001, 13'h000);
    send_byte("s1", 25'h0001, 8'hFF, 4'b0001, 13'h001);
    send_byte("s2", 25'h0002, 8'h02, 4'b0001, 13'h002);
    ioctl_download = 1'b0;
    repeat (17) step();
    chk("sum.done",  dl_done, 1'b1);
    chk("sum.value", dl_sum, 16'h0200);
    chk("sum.bad",   dl_bad, 1'b1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
